// File: rtl/ch9329_hid_transmitter_if.sv
// Handshake and data bundle between a key-scan producer and the CH9329 keyboard frame transmitter.
interface ch9329_hid_transmitter_if;
  logic        start;
  logic [7:0]  modifier;
  logic [47:0] keycodes;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, output modifier, output keycodes,
                  input  tx,    input  busy,     input  done);
  modport slave  (input  start, input  modifier, input  keycodes,
                  output tx,    output busy,     output done);
endinterface

// File: rtl/ch9329_hid_transmitter.sv
// Sends one 14-byte CH9329 "keyboard general data" frame as UART 8N1, with the
// checksum accumulated as each byte is loaded into the shifter.
module ch9329_hid_transmitter #(
  parameter int SYS_FREQ = 12_090_000,
  parameter int BAUD     = 9600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ch9329_hid_transmitter_if.slave   bus
);

  localparam int CLKS_PER_BIT = SYS_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       sum_q, sum_d;
  logic [55:0]      hold_q, hold_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       next_byte_s;

  // Frame bytes 0..12; hold = {key5..key0, modifier}. The SUM byte is taken from sum_q.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [55:0] hold);
    case (idx)
      4'd0:    frame_byte = 8'h57;
      4'd1:    frame_byte = 8'hAB;
      4'd2:    frame_byte = 8'h00;
      4'd3:    frame_byte = 8'h02;
      4'd4:    frame_byte = 8'h08;
      4'd5:    frame_byte = hold[7:0];
      4'd6:    frame_byte = 8'h00;
      4'd7:    frame_byte = hold[15:8];
      4'd8:    frame_byte = hold[23:16];
      4'd9:    frame_byte = hold[31:24];
      4'd10:   frame_byte = hold[39:32];
      4'd11:   frame_byte = hold[47:40];
      4'd12:   frame_byte = hold[55:48];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  assign next_byte_s = frame_byte(byte_idx_q + 4'd1, hold_q);

  // Next-state logic for the framer and the UART bit sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    sum_d      = sum_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d    = S_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          byte_idx_d = 4'd0;
          hold_d     = {bus.keycodes, bus.modifier};
          shift_d    = 8'h57;
          sum_d      = 8'h57;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (byte_idx_q < 4'd13) begin
            byte_idx_d = byte_idx_q + 4'd1;
            state_d    = S_START;
            tx_d       = 1'b0;
            // Byte 13 is the checksum itself; bytes 1..12 feed the running sum.
            if (byte_idx_q == 4'd12) begin
              shift_d = sum_q;
            end else begin
              shift_d = next_byte_s;
              sum_d   = sum_q + next_byte_s;
            end
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      shift_q    <= 8'h00;
      sum_q      <= 8'h00;
      hold_q     <= 56'h0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      sum_q      <= sum_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
